// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: takes the EX/MEM latch contents, issues one dcache
// request per load/store, stalls upstream until dhit, and builds the MEM/WB
// latch inputs. Also keeps a sticky halt and a saturating miss-cycle counter.
module mem_stage_ctrl #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic              dREN_out,
  input  logic              dWEN_out,
  input  logic              MemtoReg_out,
  input  logic              RegWr_out,
  input  logic              jal_s_out,
  input  logic              halt_out,
  input  logic [4:0]        wsel_out,
  input  logic [WORD_W-1:0] alu_portOut_out,
  input  logic [WORD_W-1:0] rdat2_out,
  input  logic [WORD_W-1:0] pcplusfour_out,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              wb_valid,
  output logic              wb_RegWr,
  output logic [4:0]        wb_wsel,
  output logic [WORD_W-1:0] wb_wdat,
  output logic              wb_halt,
  output logic [CNT_W-1:0]  wait_cnt
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic              halted;
  logic              is_write;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] data_q;

  logic mem_op;
  logic in_access;
  logic done;
  logic non_mem_done;
  logic reg_write;

  // Load data selection comes from the captured request type, so the
  // MemtoReg flag carries no extra information here.
  logic unused_inputs;
  assign unused_inputs = MemtoReg_out;

  assign mem_op       = in_valid & (dREN_out | dWEN_out) & ~halted;
  assign in_access    = (state == ACCESS);
  assign done         = in_access & dhit;
  assign non_mem_done = ~in_access & in_valid & ~halted & ~mem_op;
  assign reg_write    = RegWr_out & ~dWEN_out & (wsel_out != 5'd0);

  assign dmemREN   = in_access & ~is_write;
  assign dmemWEN   = in_access & is_write;
  assign dmemaddr  = addr_q;
  assign dmemstore = data_q;
  assign mem_stall = (~in_access & mem_op) | (in_access & ~dhit);

  // Request FSM: capture the request in IDLE, hold it in ACCESS until dhit;
  // also latches the sticky halt flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      halted   <= 1'b0;
      is_write <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            addr_q   <= alu_portOut_out;
            data_q   <= rdat2_out;
            is_write <= dWEN_out;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (dhit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (in_valid && halt_out && !halted) halted <= 1'b1;
    end
  end

  // MEM/WB latch inputs: written by a completing instruction, otherwise the
  // valid and write-enable drop while select and data keep their last value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_valid <= 1'b0;
      wb_RegWr <= 1'b0;
      wb_wsel  <= '0;
      wb_wdat  <= '0;
      wb_halt  <= 1'b0;
    end else begin
      if (done) begin
        wb_valid <= 1'b1;
        wb_RegWr <= reg_write;
        wb_wsel  <= wsel_out;
        if (!is_write) wb_wdat <= dmemload;
      end else if (non_mem_done) begin
        wb_valid <= 1'b1;
        wb_RegWr <= reg_write;
        wb_wsel  <= wsel_out;
        wb_wdat  <= jal_s_out ? pcplusfour_out : alu_portOut_out;
      end else begin
        wb_valid <= 1'b0;
        wb_RegWr <= 1'b0;
      end
      if (in_valid && halt_out && !halted) wb_halt <= 1'b1;
    end
  end

  // Miss-cycle counter: every ACCESS cycle without dhit, saturating at max.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt <= '0;
    end else if (in_access && !dhit && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: table of single-cycle ALU/jal vectors, hand
// sequences for loads, stores, halt and reset, then randomized traffic, all
// compared against a transaction-level reference model.
module tb_mem_stage_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid, dREN_out, dWEN_out, MemtoReg_out, RegWr_out;
  logic        jal_s_out, halt_out, dhit;
  logic [4:0]  wsel_out;
  logic [31:0] alu_portOut_out, rdat2_out, pcplusfour_out, dmemload;

  logic        dmemREN, dmemWEN, mem_stall, wb_valid, wb_RegWr, wb_halt;
  logic [31:0] dmemaddr, dmemstore, wb_wdat;
  logic [4:0]  wb_wsel;
  logic [15:0] wait_cnt;

  logic        d2_REN, d2_WEN, d2_stall, d2_valid, d2_RegWr, d2_halt;
  logic [31:0] d2_addr, d2_store, d2_wdat;
  logic [4:0]  d2_wsel;
  logic [1:0]  d2_wait_cnt;

  always #5 CLK = ~CLK;

  mem_stage_ctrl #(.WORD_W(32), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .dREN_out(dREN_out),
    .dWEN_out(dWEN_out), .MemtoReg_out(MemtoReg_out), .RegWr_out(RegWr_out),
    .jal_s_out(jal_s_out), .halt_out(halt_out), .wsel_out(wsel_out),
    .alu_portOut_out(alu_portOut_out), .rdat2_out(rdat2_out),
    .pcplusfour_out(pcplusfour_out), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .mem_stall(mem_stall), .wb_valid(wb_valid),
    .wb_RegWr(wb_RegWr), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
    .wb_halt(wb_halt), .wait_cnt(wait_cnt)
  );

  mem_stage_ctrl #(.WORD_W(32), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .dREN_out(dREN_out),
    .dWEN_out(dWEN_out), .MemtoReg_out(MemtoReg_out), .RegWr_out(RegWr_out),
    .jal_s_out(jal_s_out), .halt_out(halt_out), .wsel_out(wsel_out),
    .alu_portOut_out(alu_portOut_out), .rdat2_out(rdat2_out),
    .pcplusfour_out(pcplusfour_out), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(d2_REN), .dmemWEN(d2_WEN), .dmemaddr(d2_addr),
    .dmemstore(d2_store), .mem_stall(d2_stall), .wb_valid(d2_valid),
    .wb_RegWr(d2_RegWr), .wb_wsel(d2_wsel), .wb_wdat(d2_wdat),
    .wb_halt(d2_halt), .wait_cnt(d2_wait_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding requests as a queue, miss cycles as a raw count
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
  } req_t;

  req_t        m_pend[$];
  logic        m_halted, m_valid, m_regwr, m_halt;
  logic [4:0]  m_wsel;
  logic [31:0] m_wdat, m_addr, m_data;
  int          m_misses;

  int          ren_seen, wen_seen, stall_seen;
  logic [31:0] store_seen;

  typedef struct {
    logic        valid, regwr, jal;
    logic [4:0]  wsel;
    logic [31:0] alu, pc4;
    logic        exp_valid, exp_regwr;
    logic [4:0]  exp_wsel;
    logic [31:0] exp_wdat;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic ren, input logic wen,
                               input logic regwr, input logic jal, input logic halt,
                               input logic [4:0] wsel, input logic [31:0] alu,
                               input logic [31:0] rd2, input logic [31:0] pc4);
    in_valid        = valid;
    dREN_out        = ren;
    dWEN_out        = wen;
    MemtoReg_out    = ren & ~wen;
    RegWr_out       = regwr;
    jal_s_out       = jal;
    halt_out        = halt;
    wsel_out        = wsel;
    alu_portOut_out = alu;
    rdat2_out       = rd2;
    pcplusfour_out  = pc4;
  endtask

  task automatic model_update();
    logic memop;
    req_t r;
    if (RST) begin
      m_pend.delete();
      m_halted = 0; m_valid = 0; m_regwr = 0; m_halt = 0;
      m_wsel = 0; m_wdat = 0; m_addr = 0; m_data = 0; m_misses = 0;
    end else begin
      memop = in_valid & (dREN_out | dWEN_out) & !m_halted;
      if (m_pend.size() != 0) begin
        if (dhit) begin
          r = m_pend.pop_front();
          m_valid = 1;
          m_regwr = RegWr_out & !dWEN_out & (wsel_out != 0);
          m_wsel  = wsel_out;
          if (!r.wr) m_wdat = dmemload;
        end else begin
          m_misses++;
          m_valid = 0; m_regwr = 0;
        end
      end else if (memop) begin
        r.addr = alu_portOut_out; r.data = rdat2_out; r.wr = dWEN_out;
        m_pend.push_back(r);
        m_addr = r.addr; m_data = r.data;
        m_valid = 0; m_regwr = 0;
      end else if (in_valid && !m_halted) begin
        m_valid = 1;
        m_regwr = RegWr_out & (wsel_out != 0);
        m_wsel  = wsel_out;
        m_wdat  = jal_s_out ? pcplusfour_out : alu_portOut_out;
      end else begin
        m_valid = 0; m_regwr = 0;
      end
      if (in_valid && halt_out && !m_halted) begin
        m_halted = 1; m_halt = 1;
      end
    end
  endtask

  // One clock: request-side outputs checked mid-cycle, latch outputs after the edge
  task automatic run_cycle();
    logic busy, wr, memop;
    @(negedge CLK);
    busy  = (m_pend.size() != 0);
    wr    = busy ? m_pend[0].wr : 1'b0;
    memop = in_valid & (dREN_out | dWEN_out) & !m_halted;
    checkOutput("dmemREN", {31'b0, dmemREN}, {31'b0, busy & !wr});
    checkOutput("dmemWEN", {31'b0, dmemWEN}, {31'b0, busy & wr});
    checkOutput("mem_stall", {31'b0, mem_stall}, {31'b0, (!busy & memop) | (busy & !dhit)});
    checkOutput("dmemaddr", dmemaddr, m_addr);
    checkOutput("dmemstore", dmemstore, m_data);
    if (dmemREN) ren_seen++;
    if (dmemWEN) begin wen_seen++; store_seen = dmemstore; end
    if (mem_stall) stall_seen++;
    @(posedge CLK);
    model_update();
    #1;
    checkOutput("wb_valid", {31'b0, wb_valid}, {31'b0, m_valid});
    checkOutput("wb_RegWr", {31'b0, wb_RegWr}, {31'b0, m_regwr});
    checkOutput("wb_wsel", {27'b0, wb_wsel}, {27'b0, m_wsel});
    checkOutput("wb_wdat", wb_wdat, m_wdat);
    checkOutput("wb_halt", {31'b0, wb_halt}, {31'b0, m_halt});
    checkOutput("wait_cnt", {16'b0, wait_cnt}, (m_misses > 65535) ? 32'd65535 : m_misses);
    checkOutput("wait_cnt_w2", {30'b0, d2_wait_cnt}, (m_misses > 3) ? 32'd3 : m_misses);
  endtask

  task automatic clear_seen();
    ren_seen = 0; wen_seen = 0; stall_seen = 0; store_seen = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 5'd3,  32'h55,  32'h0,  1'b1, 1'b1, 5'd3,  32'h55};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 5'd31, 32'h77,  32'h40, 1'b1, 1'b1, 5'd31, 32'h40};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 5'd0,  32'h99,  32'h0,  1'b1, 1'b0, 5'd0,  32'h99};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 5'd7,  32'hAA,  32'h0,  1'b0, 1'b0, 5'd0,  32'h99};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 5'd9,  32'h123, 32'h0,  1'b1, 1'b0, 5'd9,  32'h123};

    RST = 1'b1; dhit = 1'b0; dmemload = 32'h0;
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(posedge CLK);
    model_update();
    #1;
    run_cycle();
    RST = 1'b0;
    clear_seen();

    // ALU / jal / $0 / bubble vectors, one per edge with no stall
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].valid, 0, 0, vecs[i].regwr, vecs[i].jal, 0,
                    vecs[i].wsel, vecs[i].alu, 32'h0, vecs[i].pc4);
      run_cycle();
      checkOutput($sformatf("vec%0d_valid", i), {31'b0, wb_valid}, {31'b0, vecs[i].exp_valid});
      checkOutput($sformatf("vec%0d_regwr", i), {31'b0, wb_RegWr}, {31'b0, vecs[i].exp_regwr});
      checkOutput($sformatf("vec%0d_wsel", i), {27'b0, wb_wsel}, {27'b0, vecs[i].exp_wsel});
      checkOutput($sformatf("vec%0d_wdat", i), wb_wdat, vecs[i].exp_wdat);
    end
    checkOutput("vec_no_stall", stall_seen, 0);

    // Load with three ACCESS cycles, dhit on the third
    clear_seen();
    applyStimulus(1, 1, 0, 1, 0, 0, 5'd5, 32'h100, 32'h0, 32'h0);
    dhit = 0;
    run_cycle();
    run_cycle();
    run_cycle();
    dhit = 1; dmemload = 32'hDEADBEEF;
    run_cycle();
    checkOutput("load_ren_cycles", ren_seen, 3);
    checkOutput("load_stall_cycles", stall_seen, 3);
    checkOutput("load_wb_valid", {31'b0, wb_valid}, 1);
    checkOutput("load_wb_wsel", {27'b0, wb_wsel}, 5);
    checkOutput("load_wb_wdat", wb_wdat, 32'hDEADBEEF);
    checkOutput("load_wb_regwr", {31'b0, wb_RegWr}, 1);
    checkOutput("load_wait_cnt", {16'b0, wait_cnt}, 2);

    // Store that hits on its first ACCESS cycle
    clear_seen();
    dhit = 0;
    applyStimulus(1, 0, 1, 1, 0, 0, 5'd6, 32'h200, 32'h1234, 32'h0);
    run_cycle();
    dhit = 1;
    run_cycle();
    checkOutput("store_wen_cycles", wen_seen, 1);
    checkOutput("store_data", store_seen, 32'h1234);
    checkOutput("store_wb_valid", {31'b0, wb_valid}, 1);
    checkOutput("store_wb_regwr", {31'b0, wb_RegWr}, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    run_cycle();

    // Halt, then a load presented while halted
    clear_seen();
    applyStimulus(1, 0, 0, 0, 0, 1, 5'd0, 32'h0, 32'h0, 32'h0);
    run_cycle();
    applyStimulus(1, 1, 0, 1, 0, 0, 5'd4, 32'h300, 32'h0, 32'h0);
    dhit = 0;
    run_cycle();
    run_cycle();
    checkOutput("halt_sticky", {31'b0, wb_halt}, 1);
    checkOutput("halt_no_ren", ren_seen, 0);
    checkOutput("halt_wb_valid", {31'b0, wb_valid}, 0);

    // Reset in the second ACCESS cycle of a load
    RST = 1;
    run_cycle();
    RST = 0;
    clear_seen();
    applyStimulus(1, 1, 0, 1, 0, 0, 5'd8, 32'h400, 32'h0, 32'h0);
    dhit = 0;
    run_cycle();
    run_cycle();
    RST = 1;
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    run_cycle();
    RST = 0;
    checkOutput("rst_ren", {31'b0, dmemREN}, 0);
    checkOutput("rst_stall", {31'b0, mem_stall}, 0);
    checkOutput("rst_addr", dmemaddr, 0);
    checkOutput("rst_wb_valid", {31'b0, wb_valid}, 0);
    checkOutput("rst_wb_wdat", wb_wdat, 0);
    checkOutput("rst_wait_cnt", {16'b0, wait_cnt}, 0);
    run_cycle();
    checkOutput("rst_no_wb", {31'b0, wb_valid}, 0);

    // Ten miss cycles: narrow counter saturates at 3
    applyStimulus(1, 1, 0, 1, 0, 0, 5'd2, 32'h500, 32'h0, 32'h0);
    dhit = 0;
    for (int i = 0; i < 11; i++) run_cycle();
    dhit = 1; dmemload = 32'hCAFE;
    run_cycle();
    checkOutput("sat_wide", {16'b0, wait_cnt}, 10);
    checkOutput("sat_narrow", {30'b0, d2_wait_cnt}, 3);
    checkOutput("sat_wb_wdat", wb_wdat, 32'hCAFE);

    // Randomized traffic; upstream holds the instruction while a request is open
    for (int n = 0; n < 400; n++) begin
      if (m_pend.size() == 0) begin
        int kind;
        logic v, rn, wn, jl, ht;
        kind = $urandom_range(0, 7);
        v  = ($urandom_range(0, 5) != 0);
        rn = (kind <= 2) || (kind == 5);
        wn = (kind == 3) || (kind == 4) || (kind == 5);
        jl = (kind == 6);
        ht = (kind >= 6) && ($urandom_range(0, 63) == 0);
        applyStimulus(v, rn, wn, 1'($urandom), jl, ht, 5'($urandom),
                      $urandom, $urandom, $urandom);
        RST = ($urandom_range(0, 99) < 2);
      end else begin
        RST = ($urandom_range(0, 49) == 0);
      end
      dhit = ($urandom_range(0, 2) == 0);
      dmemload = $urandom;
      run_cycle();
    end
    RST = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller on the consumer side of the EX/MEM pipeline latch.
- Takes the latched EX/MEM outputs, issues the data-cache request and waits for dhit, stalling upstream stages while it waits.
- Produces registered MEM/WB latch inputs: write-back data, destination register, write enable, halt.
- Sits between the EX/MEM latch and the MEM/WB latch, alongside the dcache port of the datapath.

Parameters:
- WORD_W, 32, data and address width.
- CNT_W, 16, width of the saturating wait-cycle performance counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- in_valid  input  1  EX/MEM latch holds a real instruction (0 = bubble).
- dREN_out  input  1  instruction is a load.
- dWEN_out  input  1  instruction is a store.
- MemtoReg_out  input  1  write-back data comes from memory.
- RegWr_out  input  1  instruction writes the register file.
- jal_s_out  input  1  write-back data is pcplusfour_out.
- halt_out  input  1  halt instruction.
- wsel_out  input  5  destination register.
- alu_portOut_out  input  WORD_W  ALU result / effective address.
- rdat2_out  input  WORD_W  store data.
- pcplusfour_out  input  WORD_W  return address for jal.
- dhit  input  1  dcache completed the current request.
- dmemload  input  WORD_W  load data, valid when dhit=1.
- dmemREN  output  1  dcache read request.
- dmemWEN  output  1  dcache write request.
- dmemaddr  output  WORD_W  request address.
- dmemstore  output  WORD_W  store data.
- mem_stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM latches.
- wb_valid  output  1  MEM/WB entry valid.
- wb_RegWr  output  1  register-file write enable.
- wb_wsel  output  5  register-file write select.
- wb_wdat  output  WORD_W  register-file write data.
- wb_halt  output  1  sticky halt toward write-back.
- wait_cnt  output  CNT_W  count of ACCESS cycles with dhit=0.

Behaviour:
- Reset:
  - RST=1 at a rising edge forces state IDLE, halted=0, and clears captured request regs, all wb_* outputs and wait_cnt to 0.
  - Request outputs are decoded from state, so dmemREN=dmemWEN=0 and mem_stall=0 from that edge on.
  - Reset mid-ACCESS abandons the request; no wb entry is produced.
- mem_op = in_valid & (dREN_out | dWEN_out) & !halted.
- If dREN_out and dWEN_out are both 1, the op is treated as a store and the read is ignored.
- States:
  - IDLE: if mem_op, capture addr=alu_portOut_out, store data=rdat2_out, type (write if dWEN_out) and go to ACCESS.
  - ACCESS: dmemREN=!is_write, dmemWEN=is_write, dmemaddr/dmemstore from captured regs. On dhit=1, go to IDLE.
- mem_stall = (IDLE & mem_op) | (ACCESS & !dhit). It is combinational. Upstream holds the same instruction until the dhit cycle.
- Latency:
  - A memory op takes one IDLE cycle plus N ACCESS cycles, with N≥1 ending on dhit.
  - The wb entry is registered at the dhit edge.
  - A non-memory valid instruction produces its wb entry at the next edge, with no stall.
- wb register update (each edge, not in reset):
  - Loads at the dhit edge: wb_wdat=dmemload.
  - Non-memory instructions: wb_wdat=pcplusfour_out if jal_s_out, else alu_portOut_out.
  - wb_RegWr = RegWr_out & !dWEN_out & (wsel_out≠0). A write to $0 is suppressed.
  - wb_wsel = wsel_out. wb_valid=1 for the completing instruction.
  - Every other edge loads wb_valid=0 and wb_RegWr=0. wb_wsel and wb_wdat hold their values.
- Halt:
  - in_valid & halt_out with !halted sets halted=1 and wb_halt=1 at the next edge. Both stay 1 until reset.
  - While halted: no new requests, wb_valid=0, mem_stall=0.
  - A halt arriving while in ACCESS is impossible, because upstream is stalled.
- wait_cnt: increments by 1 on each edge with state=ACCESS and dhit=0. It saturates at 2^CNT_W−1 and does not wrap.
- A bubble (in_valid=0) in IDLE produces wb_valid=0 and no request.

Test Plan:
1. Load, addr 0x100, wsel 5, dhit after 3 ACCESS cycles, dmemload 0xDEADBEEF -> dmemREN high 3 cycles, mem_stall high 3 cycles, then wb_valid=1, wb_wsel=5, wb_wdat=0xDEADBEEF, wb_RegWr=1, wait_cnt=2.
2. Store, addr 0x200, data 0x1234, RegWr_out=1, dhit on first ACCESS cycle -> dmemWEN=1, dmemstore=0x1234, one ACCESS cycle, wb_valid=1, wb_RegWr=0.
3. Back-to-back ALU op (alu 0x55, wsel 3) then jal (pc+4 0x40, wsel 31) -> no stall; wb_wdat=0x55 then 0x40 on consecutive edges.
4. ALU op with wsel 0, RegWr_out=1 -> wb_valid=1, wb_RegWr=0.
5. Halt, then a load presented -> wb_halt=1 sticky, no dmemREN, wb_valid=0.
6. Reset asserted in the 2nd ACCESS cycle of a load -> next edge IDLE, all outputs 0, wait_cnt=0, no wb entry; CNT_W=2 with 10 miss cycles -> wait_cnt stays at 3.
